drom_readout_seq: RTL and testbench

DROM_READOUT_SEQ -- requirements
Module: drom_readout_seq

---
 rtl/drom_readout_seq_pkg.sv | 23 ++
 rtl/drom_readout_seq_if.sv | 30 +++
 rtl/drom_settle_cnt.sv | 27 ++
 rtl/drom_readout_seq.sv | 152 +++++++++++++++
 tb/tb_drom_readout_seq.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/drom_readout_seq_pkg.sv
// Shared types and constants for the decode-ROM readout sequencer.
package drom_pkg;

  localparam int ADDR_W      = 5;
  localparam int DATA_W      = 16;
  localparam int CNT_W       = 4;
  localparam int IDLE_ADDR_C = 31;
  localparam int LAST_ADDR_C = 23;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CAPTURE,
    PUSH,
    NEXT
  } state_t;

  typedef enum logic {
    SWEEP,
    SINGLE
  } mode_t;

endpackage

// File: rtl/drom_readout_seq_if.sv
// Output word stream of the readout sequencer (valid/ready handshake).
// With RDO_PARITY_EN defined the stream also carries out_par.
interface drom_readout_seq_if;
  import drom_pkg::*;

  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;
`ifdef RDO_PARITY_EN
  logic              out_par;
`endif

  modport master (
    input  out_ready,
    output out_data, out_addr, out_valid
`ifdef RDO_PARITY_EN
    , out_par
`endif
  );

  modport slave (
    output out_ready,
    input  out_data, out_addr, out_valid
`ifdef RDO_PARITY_EN
    , out_par
`endif
  );

endinterface

// File: rtl/drom_settle_cnt.sv
// Loadable down-counter that times how long an address settles before capture.
module drom_settle_cnt
  import drom_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/drom_readout_seq.sv
// Decode-ROM readout sequencer: sweeps or single-reads addresses and streams words out.
// Optional feature: define RDO_PARITY_EN to add out_par (even parity of {out_addr,out_data}).
module drom_readout_seq
  import drom_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int FIRST_ADDR    = 0,
  parameter int LAST_ADDR     = LAST_ADDR_C,
  parameter int IDLE_ADDR     = IDLE_ADDR_C
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               single_req,
  input  logic [ADDR_W-1:0]  single_addr,
  input  logic               abort,
  input  logic [DATA_W-1:0]  data_in,
  output logic [ADDR_W-1:0]  address,
  output logic               rd_strobe,
  output logic               busy,
  output logic               done,
  drom_readout_seq_if.master stream
);

  localparam logic [ADDR_W-1:0] FIRST_A     = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A      = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] IDLE_A      = ADDR_W'(IDLE_ADDR);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state, state_nxt;
  mode_t             mode;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              abort_pend;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              load_sweep, load_single, advance, set_pend;

  drom_settle_cnt u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    rd_strobe   = 1'b0;
    done        = 1'b0;
    load_sweep  = 1'b0;
    load_single = 1'b0;
    advance     = 1'b0;
    set_pend    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_sweep = 1'b1;
          cnt_load   = 1'b1;
          state_nxt  = SETUP;
        end else if (single_req) begin
          load_single = 1'b1;
          cnt_load    = 1'b1;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_zero) begin
          state_nxt = CAPTURE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      CAPTURE: begin
        rd_strobe = 1'b1;
        set_pend  = abort;
        state_nxt = PUSH;
      end
      // An abort seen here or in CAPTURE is resolved in NEXT, after the word is taken.
      PUSH: begin
        set_pend = abort;
        if (stream.out_ready) state_nxt = NEXT;
      end
      NEXT: begin
        if (abort || abort_pend || (mode == SINGLE) || (cur_addr == LAST_A)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          advance   = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = SETUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= IDLE_A;
      mode       <= SWEEP;
      data_q     <= '0;
      addr_q     <= '0;
      abort_pend <= 1'b0;
    end else begin
      if (load_sweep) begin
        cur_addr <= FIRST_A;
        mode     <= SWEEP;
      end else if (load_single) begin
        cur_addr <= single_addr;
        mode     <= SINGLE;
      end else if (advance) begin
        cur_addr <= cur_addr + 1'b1;
      end
      if (rd_strobe) begin
        data_q <= data_in;
        addr_q <= cur_addr;
      end
      if (state_nxt == IDLE) abort_pend <= 1'b0;
      else if (set_pend)     abort_pend <= 1'b1;
    end
  end

`ifdef RDO_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         par_q <= 1'b0;
    else if (rd_strobe) par_q <= ^{cur_addr, data_in};
  end

  assign stream.out_par = par_q;
`endif

  assign address          = (state == IDLE) ? IDLE_A : cur_addr;
  assign busy             = (state != IDLE);
  assign stream.out_valid = (state == PUSH);
  assign stream.out_data  = data_q;
  assign stream.out_addr  = addr_q;

endmodule

// File: tb/tb_drom_readout_seq.sv
// Directed self-checking bench for drom_readout_seq (parity checks only with RDO_PARITY_EN).
module tb_drom_readout_seq;
  import drom_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        single_req = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  single_addr = 5'd0;
  logic [15:0] data_in;
  logic [4:0]  address;
  logic        rd_strobe, busy, done;
  logic        data_override = 1'b0;
  logic [15:0] override_val = 16'h0000;

  int tests = 0;
  int fails = 0;

  drom_readout_seq_if stream ();

  always #5 clk = ~clk;

  drom_readout_seq #(
    .SETTLE_CYCLES (2),
    .FIRST_ADDR    (0),
    .LAST_ADDR     (23),
    .IDLE_ADDR     (31)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .single_req  (single_req),
    .single_addr (single_addr),
    .abort       (abort),
    .data_in     (data_in),
    .address     (address),
    .rd_strobe   (rd_strobe),
    .busy        (busy),
    .done        (done),
    .stream      (stream.master)
  );

  // Each address returns a distinct word so misordered captures are visible.
  function automatic logic [15:0] data_fn(input logic [4:0] a);
    return {a, ~a, a, 1'b1} ^ 16'h3C00;
  endfunction

  assign data_in = data_override ? override_val : data_fn(address);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    tests++; if (address !== 5'd31) begin fails++; $display("[TB] FAIL reset_address: got %0d, expected 31", address); end
    tests++; if ({stream.out_valid, rd_strobe, busy, done} !== 4'b0000) begin fails++; $display("[TB] FAIL reset_flags: got %b, expected 0000", {stream.out_valid, rd_strobe, busy, done}); end
    tests++; if ({stream.out_addr, stream.out_data} !== 21'd0) begin fails++; $display("[TB] FAIL reset_word: got addr %0d data %h, expected 0/0000", stream.out_addr, stream.out_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_sweep();
    int cyc, nwords, done_cnt, first_strobe, first_valid, extra_done;
    bit last_hs, done_ok;
    nwords = 0; done_cnt = 0; first_strobe = -1; first_valid = -1; last_hs = 0; done_ok = 0; extra_done = 0;
    stream.out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    tests++; if (address !== 5'd0) begin fails++; $display("[TB] FAIL sweep_first_addr: got %0d, expected 0", address); end
    while (cyc < 300 && done_cnt == 0) begin
      if (rd_strobe && first_strobe < 0) first_strobe = cyc;
      if (stream.out_valid && first_valid < 0) first_valid = cyc;
      if (done) begin done_cnt++; done_ok = last_hs; end
      last_hs = 0;
      if (stream.out_valid && stream.out_ready) begin
        tests++;
        if (stream.out_addr !== 5'(nwords) || stream.out_data !== data_fn(5'(nwords))) begin
          fails++; $display("[TB] FAIL sweep_word: got addr %0d data %h, expected %0d/%h", stream.out_addr, stream.out_data, nwords, data_fn(5'(nwords)));
        end
        last_hs = (nwords == 23);
        nwords++;
      end
      step();
      cyc++;
    end
    tests++; if (first_strobe != 3) begin fails++; $display("[TB] FAIL sweep_strobe_latency: got cycle %0d, expected 3", first_strobe); end
    tests++; if (first_valid != 4) begin fails++; $display("[TB] FAIL sweep_valid_latency: got cycle %0d, expected 4", first_valid); end
    tests++; if (nwords != 24) begin fails++; $display("[TB] FAIL sweep_word_count: got %0d, expected 24", nwords); end
    tests++; if (done_cnt != 1 || !done_ok) begin fails++; $display("[TB] FAIL sweep_done: got count %0d after_last %0d, expected 1/1", done_cnt, done_ok); end
    tests++; if (address !== 5'd31 || busy !== 1'b0) begin fails++; $display("[TB] FAIL sweep_park: got addr %0d busy %b, expected 31/0", address, busy); end
    for (int k = 0; k < 5; k++) begin
      if (done) extra_done++;
      step();
    end
    tests++; if (extra_done != 0) begin fails++; $display("[TB] FAIL sweep_extra_done: got %0d, expected 0", extra_done); end
  endtask

  task automatic test_backpressure();
    int cyc, nwords, done_cnt;
    bit stalled;
    cyc = 0; nwords = 0; done_cnt = 0; stalled = 0;
    stream.out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 300 && done_cnt == 0) begin
      if (done) done_cnt++;
      if (stream.out_valid && stream.out_addr === 5'd7 && !stalled) begin
        stalled = 1;
        stream.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tests++;
          if (stream.out_valid !== 1'b1 || stream.out_addr !== 5'd7 || stream.out_data !== data_fn(5'd7) || address !== 5'd7) begin
            fails++; $display("[TB] FAIL bp_hold: got valid %b addr %0d data %h address %0d, expected 1/7/%h/7", stream.out_valid, stream.out_addr, stream.out_data, address, data_fn(5'd7));
          end
          step();
          cyc++;
        end
        stream.out_ready = 1'b1;
      end
      if (stream.out_valid && stream.out_ready) begin
        tests++;
        if (stream.out_addr !== 5'(nwords)) begin fails++; $display("[TB] FAIL bp_order: got addr %0d, expected %0d", stream.out_addr, nwords); end
        nwords++;
      end
      step();
      cyc++;
    end
    tests++; if (!stalled || nwords != 24 || done_cnt != 1) begin fails++; $display("[TB] FAIL bp_complete: got stalled %0d words %0d done %0d, expected 1/24/1", stalled, nwords, done_cnt); end
  endtask

  task automatic test_single();
    logic [4:0] addrs [2] = '{5'd18, 5'd27};
    int cyc, nwords, hs_cyc, done_cyc;
    stream.out_ready = 1'b1;
    foreach (addrs[i]) begin
      nwords = 0; hs_cyc = -1; done_cyc = -1;
      single_addr = addrs[i];
      single_req = 1'b1;
      step();
      single_req = 1'b0;
      single_addr = 5'd0;
      cyc = 1;
      while (cyc < 40 && done_cyc < 0) begin
        if (done) done_cyc = cyc;
        if (stream.out_valid && stream.out_ready) begin
          tests++;
          if (stream.out_addr !== addrs[i] || stream.out_data !== data_fn(addrs[i])) begin
            fails++; $display("[TB] FAIL single_word: got addr %0d data %h, expected %0d/%h", stream.out_addr, stream.out_data, addrs[i], data_fn(addrs[i]));
          end
          hs_cyc = cyc;
          nwords++;
        end
        step();
        cyc++;
      end
      tests++; if (nwords != 1) begin fails++; $display("[TB] FAIL single_count: got %0d, expected 1", nwords); end
      tests++; if (done_cyc < 0 || done_cyc != hs_cyc + 1) begin fails++; $display("[TB] FAIL single_done: got cycle %0d, expected %0d", done_cyc, hs_cyc + 1); end
      tests++; if (busy !== 1'b0 || address !== 5'd31) begin fails++; $display("[TB] FAIL single_idle: got busy %b addr %0d, expected 0/31", busy, address); end
    end
  endtask

  task automatic test_simultaneous();
    int cyc, nwords, done_cnt;
    nwords = 0; done_cnt = 0;
    stream.out_ready = 1'b1;
    start = 1'b1;
    single_req = 1'b1;
    single_addr = 5'd5;
    step();
    single_req = 1'b0;
    single_addr = 5'd0;
    cyc = 1;
    start = 1'b0;
    tests++; if (address !== 5'd0) begin fails++; $display("[TB] FAIL simul_first_addr: got %0d, expected 0", address); end
    while (cyc < 300 && done_cnt == 0) begin
      start = (cyc == 12);
      if (done) done_cnt++;
      if (stream.out_valid && stream.out_ready) begin
        tests++;
        if (stream.out_addr !== 5'(nwords)) begin fails++; $display("[TB] FAIL simul_order: got addr %0d, expected %0d", stream.out_addr, nwords); end
        nwords++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    tests++; if (nwords != 24 || done_cnt != 1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL simul_complete: got words %0d done %0d busy %b, expected 24/1/0", nwords, done_cnt, busy); end
  endtask

  task automatic test_abort();
    int cyc, nwords, done_cnt, stray;
    bit found;
    nwords = 0; done_cnt = 0; stray = 0; found = 0;
    stream.out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 100 && !found) begin
      if (rd_strobe && address === 5'd3) begin
        found = 1;
        abort = 1'b1;
      end
      step();
      abort = 1'b0;
      cyc++;
    end
    tests++; if (!found) begin fails++; $display("[TB] FAIL abort_reach_word3: got none, expected capture of addr 3"); end
    cyc = 0;
    while (cyc < 10 && done_cnt == 0) begin
      if (done) done_cnt++;
      if (stream.out_valid && stream.out_ready) begin
        tests++;
        if (stream.out_addr !== 5'd3 || stream.out_data !== data_fn(5'd3)) begin
          fails++; $display("[TB] FAIL abort_word: got addr %0d data %h, expected 3/%h", stream.out_addr, stream.out_data, data_fn(5'd3));
        end
        nwords++;
      end
      step();
      cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      if (busy || stream.out_valid) stray++;
      step();
    end
    tests++; if (nwords != 1 || done_cnt != 1 || stray != 0) begin fails++; $display("[TB] FAIL abort_end: got words %0d done %0d stray %0d, expected 1/1/0", nwords, done_cnt, stray); end
    abort = 1'b1;
    step();
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL abort_idle: got busy %b done %b, expected 0/0", busy, done); end
    abort = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int cyc, bad;
    bit found;
    found = 0; bad = 0;
    stream.out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 100 && !found) begin
      if (address === 5'd10) found = 1;
      else begin step(); cyc++; end
    end
    tests++; if (!found) begin fails++; $display("[TB] FAIL rstmid_reach: got none, expected addr 10"); end
    rst_n = 1'b0;
    #1;
    tests++; if (address !== 5'd31 || {stream.out_valid, rd_strobe, busy, done} !== 4'b0000) begin fails++; $display("[TB] FAIL rstmid_flags: got addr %0d flags %b, expected 31/0000", address, {stream.out_valid, rd_strobe, busy, done}); end
    tests++; if ({stream.out_addr, stream.out_data} !== 21'd0) begin fails++; $display("[TB] FAIL rstmid_word: got addr %0d data %h, expected 0/0000", stream.out_addr, stream.out_data); end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (busy || done || stream.out_valid) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("[TB] FAIL rstmid_no_restart: got %0d active cycles, expected 0", bad); end
  endtask

`ifdef RDO_PARITY_EN
  task automatic test_parity();
    logic [15:0] vals [2] = '{16'h0001, 16'h0003};
    logic        exps [2] = '{1'b1, 1'b0};
    int cyc;
    stream.out_ready = 1'b1;
    data_override = 1'b1;
    foreach (vals[i]) begin
      override_val = vals[i];
      single_addr = 5'd0;
      single_req = 1'b1;
      step();
      single_req = 1'b0;
      cyc = 0;
      while (cyc < 20 && !stream.out_valid) begin step(); cyc++; end
      tests++; if (stream.out_valid !== 1'b1 || stream.out_par !== exps[i]) begin fails++; $display("[TB] FAIL parity: got valid %b par %b, expected 1/%b", stream.out_valid, stream.out_par, exps[i]); end
      cyc = 0;
      while (cyc < 20 && busy) begin step(); cyc++; end
    end
    data_override = 1'b0;
  endtask
`endif

  initial begin
    stream.out_ready = 1'b1;
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_single();
    test_simultaneous();
    test_abort();
    test_reset_mid();
`ifdef RDO_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
